// File: rtl/shifter8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter8_pkg
// Description : Shared encodings for the sequential 8-bit shift unit:
//               operation codes, FSM states and small op-class helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter8_pkg;

    // Operation encodings carried on op / held in the op register
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Sequencer states; 2'b11 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // True for the five shift/rotate operations (contiguous codes LSL..ROR)
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_LSL) && (op <= OP_ROR);
    endfunction

    // True for every operation that captures d_in at accept
    function automatic logic is_load_op(input logic [2:0] op);
        return (op == OP_LOAD) || is_shift_op(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_1.sv
`default_nettype none
// ============================================================================
// Module      : mux2_1
// Description : 1-bit 2-to-1 mux cell; o_y = i_sel ? i_b : i_a.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule
`default_nettype wire

// File: rtl/shift_next8.sv
`default_nettype none
// ============================================================================
// Module      : shift_next8
// Description : Combinational one-position shift of an 8-bit value. A fill
//               bit (0, sign bit or wrapped bit) is chosen by a small mux
//               chain, then each result bit picks its left or right
//               neighbour through a per-bit 2-to-1 mux cell.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_next8
    import shifter8_pkg::*;
(
    input  logic [7:0] i_d,
    input  logic [2:0] i_op,
    output logic [7:0] o_q
);

    logic       w_left;     // data moves toward the MSB
    logic       w_rot;      // fill comes from the opposite end
    logic       w_zero;     // fill is a constant zero
    logic       w_wrap;     // bit that wraps around for rotates
    logic       w_keep;     // fill before zero forcing
    logic       w_fill;     // final bit entering the vacated position
    logic [7:0] w_from_l;   // candidate result when moving left
    logic [7:0] w_from_r;   // candidate result when moving right

    assign w_left = (i_op == OP_LSL) || (i_op == OP_ROL);
    assign w_rot  = (i_op == OP_ROL) || (i_op == OP_ROR);
    assign w_zero = (i_op == OP_LSL) || (i_op == OP_LSR);

    // ROL wraps the old MSB into bit 0, ROR wraps the old LSB into bit 7
    mux2_1 u_wrap (.i_a(i_d[0]), .i_b(i_d[7]), .i_sel(w_left), .o_y(w_wrap));
    // ASR replicates the sign bit; rotates use the wrapped bit
    mux2_1 u_sign (.i_a(i_d[7]), .i_b(w_wrap), .i_sel(w_rot),  .o_y(w_keep));
    // Logical shifts force the fill to zero
    mux2_1 u_zero (.i_a(w_keep), .i_b(1'b0),   .i_sel(w_zero), .o_y(w_fill));

    assign w_from_l = {i_d[6:0], w_fill};
    assign w_from_r = {w_fill, i_d[7:1]};

    for (genvar i = 0; i < 8; i++) begin : g_bit
        mux2_1 u_dir (
            .i_a  (w_from_r[i]),
            .i_b  (w_from_l[i]),
            .i_sel(w_left),
            .o_y  (o_q[i])
        );
    end

endmodule
`default_nettype wire

// File: rtl/shifter8_seq.sv
`default_nettype none
// ============================================================================
// Module      : shifter8_seq
// Description : Sequential 8-bit shift unit. Accepts an op/amount/operand on
//               start while idle, then shifts the registered result one
//               position per clock, pulsing done for one cycle at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter8_seq
    import shifter8_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] amt,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done
);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;
    logic [2:0] r_op;
    logic [2:0] w_op_next;
    logic [7:0] r_d_out;
    logic [7:0] w_d_next;
    logic [7:0] w_shifted;

    shift_next8 u_shift_next (
        .i_d (r_d_out),
        .i_op(r_op),
        .o_q (w_shifted)
    );

    // Register update; reset wins over any in-flight operation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_op    <= OP_NOP;
            r_d_out <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_d_out <= w_d_next;
        end
    end

    // Next-state, counter and load/shift/hold select for the result register
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        w_d_next     = r_d_out;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_next  = op;
                    w_cnt_next = amt;
                    if (is_load_op(op)) begin
                        w_d_next = d_in;
                    end
                    if (is_shift_op(op) && (amt != 3'd0)) begin
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                w_d_next   = w_shifted;
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                // Unused encoding: recover without touching the result
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign d_out = r_d_out;
    assign busy  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done  = (r_state == ST_DONE);

endmodule
`default_nettype wire
